pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Registered program-counter generator for the pipelined RV32 core. Holds the
//  fetch PC and advances it sequentially under a fetch valid/ready handshake.
//  Takes branch/jump resolution from execute and redirects to the resolved target.
//  Traps misaligned targets to a fixed vector. Supports halt/resume.
//  Sits between the execute-stage branch unit and the instruction-fetch stage.
// PARAMETERS
//  XLEN       32            data/address width
//  RESET_VEC  32'h0000_0000 PC loaded on reset
//  TRAP_VEC   32'h0000_0100 PC loaded on misaligned-target trap
//  IALIGN     32            required target alignment in bits: 32 (target[1:0]==0) or 16 (target[0]==0)
//  ILEN_B     4             sequential increment in bytes
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst          in   1     asynchronous, active-high reset
//  fetch_ready  in   1     fetch stage accepts fetch_pc this cycle
//  fetch_valid  out  1     fetch_pc is valid
//  fetch_pc     out  XLEN  current fetch address
//  ex_valid     in   1     execute-stage control-flow info is valid
//  ex_kind      in   2     0=none/seq, 1=cond branch, 2=JAL, 3=JALR
//  ex_pc        in   XLEN  PC of the executing instruction
//  ex_imm       in   XLEN  sign-extended immediate
//  ex_rs1       in   XLEN  rs1 value (JALR base)
//  ex_taken     in   1     condition result for ex_kind==1
//  redirect     out  1     combinational: execute redirects (or traps) this cycle; fetch/decode squash
//  trap         out  1     registered one-cycle pulse: misaligned target trapped
//  trap_epc     out  XLEN  ex_pc of the trapping instruction; held until next trap
//  trap_tval    out  XLEN  offending target; held until next trap
//  halt_req     in   1     request to stop fetching
//  resume       in   1     leave HALT
//  halted       out  1     state==HALT
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_VEC, state=BOOT, fetch_valid=0, trap=0,
//   trap_epc=0, trap_tval=0, halted=0.
//  FSM: BOOT -> RUN unconditionally on the next edge.
//   RUN -> HALT when halt_req. HALT -> RUN when resume (halt_req ignored in HALT).
//  fetch_valid = (state==RUN).
//  Target, computed modulo 2^XLEN:
//   kind 1/2: ex_pc+ex_imm. kind 3: (ex_rs1+ex_imm) & ~1.
//  take = ex_valid & (kind==2 | kind==3 | (kind==1 & ex_taken)).
//   Not-taken branch and kind 0 cause no redirect.
//  misaligned = take & (IALIGN==32 ? target[1:0]!=0 : target[0]!=0).
//  redirect = take; asserted in any state; not gated by fetch_ready.
//  Next-PC priority, highest first:
//   (1) misaligned: pc<=TRAP_VEC, trap<=1, trap_epc<=ex_pc, trap_tval<=target.
//   (2) take: pc<=target.
//   (3) RUN & fetch_valid & fetch_ready: pc<=pc+ILEN_B.
//   (4) otherwise hold.
//  trap is 1 for exactly one cycle per trapping event.
//  Latency: redirect target appears on fetch_pc the cycle after ex_valid.
//  Redirect in BOOT or HALT: PC updates; state is unaffected.
//  Redirect together with halt_req in RUN: PC takes the target and state->HALT.
//   No sequential advance occurs that cycle.
//  halt_req with fetch_ready in RUN: the handshake completes, so PC advances, then HALT.
//  Wrap-around: pc=32'hFFFF_FFFC advances to 0; no trap, no flag.
//  Reset asserted mid-operation: immediate return to reset values, any trap pulse dropped.
// TESTING
//  Sequential: reset, then fetch_ready=1 for 4 cycles -> fetch_pc 0,4,8,C,10.
//   fetch_ready=0 -> PC holds.
//  Branch: ex_kind=1, ex_pc=0x40, ex_imm=-8, taken=1 -> redirect=1, next fetch_pc=0x38.
//   Same with taken=0 -> redirect=0, PC keeps advancing.
//  JALR: ex_rs1=0x1001, ex_imm=2 -> fetch_pc=0x1002 with IALIGN=16.
//   With IALIGN=32 -> fetch_pc=TRAP_VEC, trap=1 for one cycle, trap_epc=ex_pc, trap_tval=0x1002.
//  Halt: halt_req in RUN -> halted=1, fetch_valid=0, PC frozen.
//   JAL to 0x200 while halted -> PC=0x200, still halted.
//   resume -> fetch from 0x200.
//  Wrap/reset: force PC to 0xFFFF_FFFC with a JAL, fetch_ready=1 -> PC=0.
//   Assert rst mid-redirect -> PC=RESET_VEC, fetch_valid=0, trap=0.

Source files
------------

// File: rtl/pc_gen_if.sv
// Bundle of fetch handshake, execute control-flow, trap and halt signals around pc_gen.
// The master side is the PC generator itself; the slave side is the surrounding pipeline.
interface pc_gen_if #(
  parameter int XLEN = 32
) ();

  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;

  logic            ex_valid;
  logic [1:0]      ex_kind;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1;
  logic            ex_taken;

  logic            redirect;
  logic            trap;
  logic [XLEN-1:0] trap_epc;
  logic [XLEN-1:0] trap_tval;

  logic            halt_req;
  logic            resume;
  logic            halted;

  modport master (
    input  fetch_ready,
    output fetch_valid, fetch_pc,
    input  ex_valid, ex_kind, ex_pc, ex_imm, ex_rs1, ex_taken,
    output redirect, trap, trap_epc, trap_tval,
    input  halt_req, resume,
    output halted
  );

  modport slave (
    output fetch_ready,
    input  fetch_valid, fetch_pc,
    output ex_valid, ex_kind, ex_pc, ex_imm, ex_rs1, ex_taken,
    input  redirect, trap, trap_epc, trap_tval,
    output halt_req, resume,
    input  halted
  );

endinterface

// File: rtl/pc_gen.sv
// Registered fetch program counter for the RV32 pipeline: sequential advance, execute
// redirects, misaligned-target trap to a fixed vector, and halt/resume control.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              IALIGN    = 32,
  parameter int              ILEN_B    = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_JAL    = 2'd2;
  localparam logic [1:0] KIND_JALR   = 2'd3;

  localparam logic [XLEN-1:0] SEQ_STEP  = XLEN'(ILEN_B);
  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target;
  logic            take;
  logic            misaligned;
  logic            advance;
  logic            trap_q;
  logic [XLEN-1:0] trap_epc_q;
  logic [XLEN-1:0] trap_tval_q;

  // Redirect target and its legality are resolved combinationally from execute.
  always_comb begin
    target = bus.ex_pc + bus.ex_imm;
    if (bus.ex_kind == KIND_JALR) begin
      target = (bus.ex_rs1 + bus.ex_imm) & JALR_MASK;
    end

    take = bus.ex_valid &&
           ((bus.ex_kind == KIND_JAL) ||
            (bus.ex_kind == KIND_JALR) ||
            ((bus.ex_kind == KIND_BRANCH) && bus.ex_taken));

    if (IALIGN == 32) begin
      misaligned = take && (target[1:0] != 2'b00);
    end else begin
      misaligned = take && target[0];
    end
  end

  assign advance = (state == RUN) && bus.fetch_ready;

  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:    state_next = RUN;
      RUN:     if (bus.halt_req) state_next = HALT;
      HALT:    if (bus.resume)   state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // A trap outranks a normal redirect, which outranks the sequential fetch step.
  always_comb begin
    pc_next = pc;
    if (misaligned) begin
      pc_next = TRAP_VEC;
    end else if (take) begin
      pc_next = target;
    end else if (advance) begin
      pc_next = pc + SEQ_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_VEC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Trap cause registers keep the last event visible until the next trap overwrites them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q      <= 1'b0;
      trap_epc_q  <= '0;
      trap_tval_q <= '0;
    end else begin
      trap_q <= misaligned;
      if (misaligned) begin
        trap_epc_q  <= bus.ex_pc;
        trap_tval_q <= target;
      end
    end
  end

  assign bus.fetch_valid = (state == RUN);
  assign bus.fetch_pc    = pc;
  assign bus.redirect    = take;
  assign bus.trap        = trap_q;
  assign bus.trap_epc    = trap_epc_q;
  assign bus.trap_tval   = trap_tval_q;
  assign bus.halted      = (state == HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: one instance per alignment mode, a reference model of the PC rules,
// and directed scenarios with literal expectations.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        fetch_ready;
  logic        ex_valid;
  logic [1:0]  ex_kind;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        ex_taken;
  logic        halt_req;
  logic        resume;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen_if #(.XLEN(32)) if32 ();
  pc_gen_if #(.XLEN(32)) if16 ();

  assign if32.fetch_ready = fetch_ready;
  assign if32.ex_valid    = ex_valid;
  assign if32.ex_kind     = ex_kind;
  assign if32.ex_pc       = ex_pc;
  assign if32.ex_imm      = ex_imm;
  assign if32.ex_rs1      = ex_rs1;
  assign if32.ex_taken    = ex_taken;
  assign if32.halt_req    = halt_req;
  assign if32.resume      = resume;

  assign if16.fetch_ready = fetch_ready;
  assign if16.ex_valid    = ex_valid;
  assign if16.ex_kind     = ex_kind;
  assign if16.ex_pc       = ex_pc;
  assign if16.ex_imm      = ex_imm;
  assign if16.ex_rs1      = ex_rs1;
  assign if16.ex_taken    = ex_taken;
  assign if16.halt_req    = halt_req;
  assign if16.resume      = resume;

  pc_gen #(.IALIGN(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  pc_gen #(.IALIGN(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: index 0 is the 32-bit-aligned instance, index 1 the 16-bit one.
  logic [31:0] m_pc   [2];
  logic [31:0] m_epc  [2];
  logic [31:0] m_tval [2];
  bit          m_boot [2];
  bit          m_halt [2];
  bit          m_trap [2];

  function automatic logic [31:0] calcTarget();
    if (ex_kind == 2'd3) return (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
    return ex_pc + ex_imm;
  endfunction

  function automatic bit calcTake();
    return ex_valid && (ex_kind == 2'd2 || ex_kind == 2'd3 || (ex_kind == 2'd1 && ex_taken));
  endfunction

  function automatic bit calcMisaligned(input int align_bits);
    logic [31:0] t;
    t = calcTarget();
    return calcTake() && ((t % (align_bits / 8)) != 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      bit running;
      bit mis;
      if (rst) begin
        m_pc[d]   = 32'h0;
        m_epc[d]  = 32'h0;
        m_tval[d] = 32'h0;
        m_boot[d] = 1'b1;
        m_halt[d] = 1'b0;
        m_trap[d] = 1'b0;
      end else begin
        running = !m_boot[d] && !m_halt[d];
        mis     = calcMisaligned(d == 0 ? 32 : 16);
        m_trap[d] = mis;
        if (mis) begin
          m_pc[d]   = 32'h0000_0100;
          m_epc[d]  = ex_pc;
          m_tval[d] = calcTarget();
        end else if (calcTake()) begin
          m_pc[d] = calcTarget();
        end else if (running && fetch_ready) begin
          m_pc[d] = m_pc[d] + 32'd4;
        end
        if (m_boot[d]) m_boot[d] = 1'b0;
        else if (running && halt_req) m_halt[d] = 1'b1;
        else if (m_halt[d] && resume) m_halt[d] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("m32 fetch_pc",    if32.fetch_pc,    m_pc[0]);
    checkOutput("m32 fetch_valid", 32'(if32.fetch_valid), 32'(!m_boot[0] && !m_halt[0]));
    checkOutput("m32 halted",      32'(if32.halted), 32'(m_halt[0]));
    checkOutput("m32 redirect",    32'(if32.redirect), 32'(calcTake()));
    checkOutput("m32 trap",        32'(if32.trap),   32'(m_trap[0]));
    checkOutput("m32 trap_epc",    if32.trap_epc,    m_epc[0]);
    checkOutput("m32 trap_tval",   if32.trap_tval,   m_tval[0]);
    checkOutput("m16 fetch_pc",    if16.fetch_pc,    m_pc[1]);
    checkOutput("m16 fetch_valid", 32'(if16.fetch_valid), 32'(!m_boot[1] && !m_halt[1]));
    checkOutput("m16 halted",      32'(if16.halted), 32'(m_halt[1]));
    checkOutput("m16 redirect",    32'(if16.redirect), 32'(calcTake()));
    checkOutput("m16 trap",        32'(if16.trap),   32'(m_trap[1]));
    checkOutput("m16 trap_epc",    if16.trap_epc,    m_epc[1]);
    checkOutput("m16 trap_tval",   if16.trap_tval,   m_tval[1]);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] kind, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] rs1, input logic taken);
    ex_valid = valid;
    ex_kind  = kind;
    ex_pc    = pc;
    ex_imm   = imm;
    ex_rs1   = rs1;
    ex_taken = taken;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    fetch_ready = 1'b0;
    halt_req = 1'b0;
    resume = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset fetch_pc",    if32.fetch_pc, 32'h0);
    checkOutput("reset fetch_valid", 32'(if32.fetch_valid), 32'd0);
    checkOutput("reset trap",        32'(if32.trap), 32'd0);
    checkOutput("reset halted",      32'(if32.halted), 32'd0);

    // Sequential fetch out of BOOT
    rst = 1'b0;
    fetch_ready = 1'b1;
    cycle();
    checkOutput("boot->run fetch_pc",    if32.fetch_pc, 32'h0);
    checkOutput("boot->run fetch_valid", 32'(if32.fetch_valid), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checkOutput("seq fetch_pc", if32.fetch_pc, 32'(4 * i));
    end
    fetch_ready = 1'b0;
    repeat (2) cycle();
    checkOutput("stall hold fetch_pc", if32.fetch_pc, 32'h10);

    // Taken branch backwards, then the same branch not taken
    fetch_ready = 1'b1;
    applyStimulus(1'b1, 2'd1, 32'h40, 32'hFFFF_FFF8, 32'h0, 1'b1);
    #1;
    checkOutput("branch taken redirect", 32'(if32.redirect), 32'd1);
    cycle();
    checkOutput("branch target fetch_pc", if32.fetch_pc, 32'h38);
    applyStimulus(1'b1, 2'd1, 32'h40, 32'hFFFF_FFF8, 32'h0, 1'b0);
    #1;
    checkOutput("branch not-taken redirect", 32'(if32.redirect), 32'd0);
    cycle();
    checkOutput("not-taken advance fetch_pc", if32.fetch_pc, 32'h3C);

    // JALR to a halfword-aligned target: legal for IALIGN=16, trap for IALIGN=32
    applyStimulus(1'b1, 2'd3, 32'h50, 32'h2, 32'h1001, 1'b0);
    cycle();
    checkOutput("jalr16 fetch_pc",  if16.fetch_pc, 32'h1002);
    checkOutput("jalr16 trap",      32'(if16.trap), 32'd0);
    checkOutput("jalr32 fetch_pc",  if32.fetch_pc, 32'h100);
    checkOutput("jalr32 trap",      32'(if32.trap), 32'd1);
    checkOutput("jalr32 trap_epc",  if32.trap_epc, 32'h50);
    checkOutput("jalr32 trap_tval", if32.trap_tval, 32'h1002);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    cycle();
    checkOutput("trap pulse ends",  32'(if32.trap), 32'd0);
    checkOutput("trap epc held",    if32.trap_epc, 32'h50);
    checkOutput("after trap fetch_pc", if32.fetch_pc, 32'h104);
    checkOutput("jalr16 advance fetch_pc", if16.fetch_pc, 32'h1006);

    // Halt, redirect while halted, resume
    fetch_ready = 1'b0;
    halt_req = 1'b1;
    cycle();
    checkOutput("halt halted",      32'(if32.halted), 32'd1);
    checkOutput("halt fetch_valid", 32'(if32.fetch_valid), 32'd0);
    halt_req = 1'b0;
    fetch_ready = 1'b1;
    cycle();
    checkOutput("halt frozen fetch_pc", if32.fetch_pc, 32'h104);
    applyStimulus(1'b1, 2'd2, 32'h180, 32'h80, 32'h0, 1'b0);
    cycle();
    checkOutput("jal halted fetch_pc", if32.fetch_pc, 32'h200);
    checkOutput("jal halted halted",   32'(if32.halted), 32'd1);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    resume = 1'b1;
    cycle();
    checkOutput("resume fetch_valid", 32'(if32.fetch_valid), 32'd1);
    checkOutput("resume fetch_pc",    if32.fetch_pc, 32'h200);
    resume = 1'b0;
    cycle();
    checkOutput("resume advance fetch_pc", if32.fetch_pc, 32'h204);

    // halt_req together with a completed handshake still advances
    halt_req = 1'b1;
    cycle();
    checkOutput("halt+ready fetch_pc", if32.fetch_pc, 32'h208);
    checkOutput("halt+ready halted",   32'(if32.halted), 32'd1);
    halt_req = 1'b0;
    resume = 1'b1;
    cycle();
    resume = 1'b0;

    // Redirect together with halt_req: target taken, no sequential step, then halted
    applyStimulus(1'b1, 2'd2, 32'h300, 32'h10, 32'h0, 1'b0);
    halt_req = 1'b1;
    cycle();
    checkOutput("redirect+halt fetch_pc", if32.fetch_pc, 32'h310);
    checkOutput("redirect+halt halted",   32'(if32.halted), 32'd1);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    halt_req = 1'b0;
    resume = 1'b1;
    cycle();
    resume = 1'b0;

    // Wrap-around at the top of the address space
    applyStimulus(1'b1, 2'd2, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    cycle();
    checkOutput("wrap setup fetch_pc", if32.fetch_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    cycle();
    checkOutput("wrap fetch_pc", if32.fetch_pc, 32'h0);
    checkOutput("wrap trap",     32'(if32.trap), 32'd0);

    // Odd target traps in both modes, then reset lands while the pulse is high
    applyStimulus(1'b1, 2'd2, 32'h20, 32'h7, 32'h0, 1'b0);
    cycle();
    checkOutput("odd jal16 trap", 32'(if16.trap), 32'd1);
    checkOutput("odd jal32 tval", if32.trap_tval, 32'h27);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid reset fetch_pc",    if32.fetch_pc, 32'h0);
    checkOutput("mid reset fetch_valid", 32'(if32.fetch_valid), 32'd0);
    checkOutput("mid reset trap",        32'(if32.trap), 32'd0);
    checkOutput("mid reset trap_tval",   if16.trap_tval, 32'h0);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    cycle();
    rst = 1'b0;
    repeat (2) cycle();
    checkOutput("post reset fetch_pc", if32.fetch_pc, 32'h4);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
